bu_intt: RTL and testbench

BU_INTT -- requirements
Module: bu_intt

---
 rtl/bu_intt.sv | 104 ++++++++++
 tb/tb_bu_intt.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bu_intt.sv
// Pipelined Gentleman-Sande inverse-NTT butterfly for q = 3329 (ML-KEM).
// Optional macro BU_INTT_HALVE_EN scales both results by 2^-1 mod q.
module bu_intt (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] A_In,
  input  logic [11:0] B_In,
  input  logic [11:0] W_In,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] A_Out,
  output logic [11:0] B_Out
);
  localparam logic [12:0] Q         = 13'd3329;
  localparam logic [36:0] BARRETT_M = 37'd5039;

`ifdef BU_INTT_HALVE_EN
  // x/2 mod q: odd values are made even by adding q before the shift.
  function automatic logic [11:0] halve(input logic [11:0] x);
    logic [12:0] t;
    t = x[0] ? ({1'b0, x} + Q) : {1'b0, x};
    return 12'(t >> 1);
  endfunction
`endif

  // Handshake: input transfers on in_valid && in_ready, output transfers on
  // out_valid && out_ready; the whole pipeline freezes only when a valid
  // result is sitting at the output and downstream refuses it.
  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  logic        s1_v, s2_v, s3_v;
  logic [11:0] s1_sum, s1_diff, s1_w;
  logic [11:0] s2_sum, s3_sum;
  logic [23:0] s2_prod;
  logic [12:0] s3_r;

  logic [12:0] sum_raw, diff_raw;
  logic [11:0] s1_sum_d, s1_diff_d;
  logic [12:0] bar_t, s3_r_d;
  logic [23:0] bar_tq;
  logic [11:0] b_red, b_fin;

  always_comb begin
    sum_raw   = {1'b0, A_In} + {1'b0, B_In};
    diff_raw  = {1'b0, A_In} - {1'b0, B_In};
    s1_diff_d = 12'((A_In < B_In) ? diff_raw + Q : diff_raw);
`ifdef BU_INTT_HALVE_EN
    s1_sum_d  = halve(12'((sum_raw >= Q) ? sum_raw - Q : sum_raw));
`else
    s1_sum_d  = 12'((sum_raw >= Q) ? sum_raw - Q : sum_raw);
`endif
  end

  // Barrett: t underestimates p/q by at most one, so r lands in 0..2q-1.
  always_comb begin
    bar_t  = 13'(({13'd0, s2_prod} * BARRETT_M) >> 24);
    bar_tq = {11'd0, bar_t} * 24'd3329;
    s3_r_d = 13'(s2_prod - bar_tq);
  end

  always_comb begin
    b_red = 12'((s3_r >= Q) ? s3_r - Q : s3_r);
`ifdef BU_INTT_HALVE_EN
    b_fin = halve(b_red);
`else
    b_fin = b_red;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      out_valid <= 1'b0;
      A_Out     <= 12'd0;
      B_Out     <= 12'd0;
    end else if (advance) begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      s3_v      <= s2_v;
      out_valid <= s3_v;
      A_Out     <= s3_sum;
      B_Out     <= b_fin;
    end
  end

  // Datapath registers need no reset; their valid bits gate them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sum  <= s1_sum_d;
      s1_diff <= s1_diff_d;
      s1_w    <= W_In;
      s2_sum  <= s1_sum;
      s2_prod <= {12'd0, s1_diff} * {12'd0, s1_w};
      s3_sum  <= s2_sum;
      s3_r    <= s3_r_d;
    end
  end
endmodule

// File: tb/tb_bu_intt.sv
// Bench for bu_intt: driver tasks push expected results into a queue,
// a negedge monitor pops and compares on every output transfer.
module tb_bu_intt;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a_in, b_in, w_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] a_out, b_out;

  bu_intt dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A_In(a_in), .B_In(b_in), .W_In(w_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .A_Out(a_out), .B_Out(b_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_sent = 0;
  int n_out  = 0;

  // {a_expected, b_expected, check_enable}; lat_q holds the cycle the
  // result must appear in, or -1 when latency is not being checked.
  logic [24:0] exp_q[$];
  int          lat_q[$];

  task automatic check(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int halve_ref(int x);
    return (x * 1665) % Q;
  endfunction

  function automatic logic [23:0] model(int a, int b, int w);
    int s;
    int d;
    int m;
    s = (a + b) % Q;
    d = (((a - b) % Q) + Q) % Q;
    m = (d * w) % Q;
`ifdef BU_INTT_HALVE_EN
    s = halve_ref(s);
    m = halve_ref(m);
`endif
    return {12'(s), 12'(m)};
  endfunction

  task automatic send(int a, int b, int w, bit chk, bit lat);
    int acc;
    int tries;
    in_valid = 1'b1;
    a_in = 12'(a);
    b_in = 12'(b);
    w_in = 12'(w);
    tries = 0;
    do begin
      @(negedge clk);
      acc = int'(in_ready);
      @(posedge clk);
      #1;
      tries++;
    end while (acc == 0 && tries < 200);
    if (acc == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck low for %0d cycles", tries);
    end else begin
      exp_q.push_back({model(a, b, w), chk});
      lat_q.push_back(lat ? cyc + 3 : -1);
      n_sent++;
    end
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic        hold_v = 1'b0;
  logic [11:0] hold_a, hold_b;
  logic [24:0] e;
  int          l;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_a_stable", int'(a_out), int'(hold_a));
        check("stall_b_stable", int'(b_out), int'(hold_b));
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", int'(in_ready), 0);
        hold_v = 1'b1;
        hold_a = a_out;
        hold_b = b_out;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: a=%0d b=%0d with nothing expected", a_out, b_out);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          if (e[0]) begin
            check("a_out", int'(a_out), int'(e[24:13]));
            check("b_out", int'(b_out), int'(e[12:1]));
          end
          if (l >= 0) check("latency", cyc, l);
          n_out++;
        end
      end
    end
  end

  bit rnd_done = 1'b0;

  initial begin
    int base;
    rst = 1'b1;
    in_valid = 1'b0;
    a_in = 12'd0;
    b_in = 12'd0;
    w_in = 12'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_a_out", int'(a_out), 0);
    check("reset_b_out", int'(b_out), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Directed basics and boundaries, each alone in the pipe.
    send(16, 20, 3, 1, 1);        idle(6);
    send(800, 3, 7, 1, 1);        idle(6);
    send(3328, 3328, 3328, 1, 1); idle(6);
    send(0, 3328, 3328, 1, 1);    idle(6);

    // Back-to-back stream with an out-of-contract operand in the middle.
    send(100, 200, 300, 1, 1);
    send(4095, 4000, 4095, 0, 1);
    send(5, 6, 7, 1, 1);
    send(3328, 0, 1, 1, 1);
    idle(8);

    // Backpressure: 8 inputs back-to-back, out_ready low for 3 cycles.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom_range(0, 3328), $urandom_range(0, 3328), $urandom_range(0, 3328), 1, 0);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(10);
    check("backpressure_count", n_out - base, 8);

    // Reset with three butterflies in flight.
    send(1, 2, 3, 1, 1);
    send(4, 5, 6, 1, 1);
    send(7, 8, 9, 1, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    n_sent -= 3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(30, 40, 50, 1, 1);
    idle(6);

    // Random traffic with random bubbles and random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send($urandom_range(0, 3328), $urandom_range(0, 3328), $urandom_range(0, 3328), 1, 0);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("delivered_total", n_out, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
